ssd_value_latch: RTL and testbench
==================================

Name: ssd_value_latch

Overview:
- Upstream feeder for the 4-digit seven-segment display driver.
- Selects one of four 32-bit processor debug values (PC, instruction, ALU result, register read data) using board switches.
- Saturates the selected value to the display's 13-bit input range and re-samples it at a throttled rate so digits stay readable.
- A debounced push-button toggles a freeze mode that holds the shown value.

Parameters:
- DB_CYCLES, 20'd1000000, consecutive stable cycles required to accept a new button level (min 2).
- UPDATE_CYCLES, 24'd5000000, cycles between display samples in LIVE state (min 2).
- MAX_VAL, 13'd8191, saturation ceiling for num.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sel  in  2  source select: 0=pc, 1=instr, 2=alu_res, 3=reg_data
- pc  in  32  program counter
- instr  in  32  current instruction
- alu_res  in  32  ALU result
- reg_data  in  32  register file read data
- btn_raw  in  1  raw, asynchronous freeze button (active-high)
- num  out  13  value to display driver, registered
- ovf  out  1  registered; 1 when the last sampled source exceeded MAX_VAL
- frozen  out  1  registered; 1 while in FROZEN state

Behaviour:
- Reset (rst=0, asynchronous): num=0, ovf=0, frozen=0, state=LIVE, tick counter=0, debounce counter=0, synchroniser flops=0, debounced level=0, sel_q=0.
- All logic is clocked on the rising edge of clk.
- Button synchroniser: two flops, btn_raw -> s1 -> s2.
- Debounce:
  - if s2 == db_level, db_cnt <= 0.
  - otherwise db_cnt increments; when db_cnt == DB_CYCLES-1, db_level <= s2 and db_cnt <= 0.
  - A press therefore registers DB_CYCLES+2 cycles after a stable edge on btn_raw.
  - Glitches shorter than DB_CYCLES cycles are ignored.
- Press event: a 1-cycle pulse when db_level rises 0->1. Release does nothing.
- State machine, two states:
  - LIVE: a press event moves to FROZEN; frozen <= 1 on the same edge.
  - FROZEN: a press event moves to LIVE; frozen <= 0, and a load is forced on that same edge.
- Tick counter (runs in both states):
  - counts 0..UPDATE_CYCLES-1, then wraps to 0.
  - tick is asserted when the count equals UPDATE_CYCLES-1.
- Load conditions, in LIVE only, each producing one load at the clock edge:
  - tick is asserted, or
  - sel != sel_q (a select change), or
  - a FROZEN->LIVE transition.
- On a select change in LIVE, the tick counter is also reset to 0.
- sel_q <= sel every cycle, regardless of state.
- Load operation:
  - v = source selected by the current sel.
  - num <= (v > MAX_VAL) ? MAX_VAL : v[12:0]; ovf <= (v > MAX_VAL). The comparison is unsigned and 32-bit.
- In FROZEN, num and ovf hold their values; sel changes and ticks are ignored.
- Simultaneous tick and select change: exactly one load occurs, the counter resets to 0, and the next tick comes UPDATE_CYCLES cycles later.
- Press event coinciding with tick in LIVE: the move to FROZEN wins and no load occurs.
- Reset asserted mid-debounce or mid-count: all state returns to reset values immediately; a button held through reset deassertion must pass the full debounce before it counts as a press.

Optional Feature:
- Macro: SSD_SIGNED_MAG_EN.
- Defined:
  - the source is treated as two's-complement signed.
  - the load uses the magnitude |v|, saturated to MAX_VAL.
  - an extra output port neg (1 bit, reset 0) is registered with v[31] on every load. The magnitude of 0x80000000 saturates to MAX_VAL.
- Undefined:
  - the source is unsigned.
  - the neg port does not exist.

Test Plan (DB_CYCLES=4, UPDATE_CYCLES=8):
- Release rst with sel=0, pc=0x00000064 -> num=0 until the first tick; num=100, ovf=0 by cycle 8 after reset release.
- In LIVE, sel 0->2 with alu_res=0x00002710 -> next edge num=8191, ovf=1; the following tick is 8 cycles later.
- btn_raw high for 3 cycles, then low -> frozen stays 0. btn_raw held high -> frozen=1 at cycle 6 after the rise; then changing pc to 5 leaves num unchanged.
- Second debounced press while FROZEN with pc=5 -> frozen=0 and num=5 on the same edge.
- Assert rst mid-count with num=100, frozen=1 -> num=0, frozen=0, ovf=0 immediately, without waiting for a clock edge.
- With SSD_SIGNED_MAG_EN, sel=1, instr=0xFFFFFF9C -> num=100, neg=1. With instr=0x80000000 -> num=8191, neg=1.

Source files
------------

// File: rtl/ssd_value_latch.sv
// Selects a debug source, saturates it to the 13-bit display range and re-samples it at a throttled rate.
// A debounced button toggles freeze; define SSD_SIGNED_MAG_EN to show the signed magnitude plus a neg flag.
module ssd_value_latch #(
  parameter logic [19:0] DB_CYCLES     = 20'd1000000,
  parameter logic [23:0] UPDATE_CYCLES = 24'd5000000,
  parameter logic [12:0] MAX_VAL       = 13'd8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_res,
  input  logic [31:0] reg_data,
  input  logic        btn_raw,
`ifdef SSD_SIGNED_MAG_EN
  output logic        neg,
`endif
  output logic [12:0] num,
  output logic        ovf,
  output logic        frozen
);

  typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic        db_level_q, db_level_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  sel_q;
  logic [12:0] num_q, num_d;
  logic        ovf_q, ovf_d;
  logic        press, tick, sel_chg, load;
  logic [31:0] src, mag;
  logic        sat;
`ifdef SSD_SIGNED_MAG_EN
  logic        neg_q, neg_d;
`endif

  // The press pulse fires on the same edge the debounced level rises, not one cycle later.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    press      = 1'b0;
    if (s2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_CYCLES - 20'd1) begin
      db_level_d = s2_q;
      db_cnt_d   = '0;
      press      = s2_q;
    end else begin
      db_cnt_d = db_cnt_q + 20'd1;
    end
  end

  assign tick    = (tick_cnt_q == UPDATE_CYCLES - 24'd1);
  assign sel_chg = (sel != sel_q);

  // A freeze request outranks any load due on the same edge; unfreezing always forces a load.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 24'd1;
    case (state_q)
      LIVE: begin
        if (sel_chg) tick_cnt_d = '0;
        if (press) state_d = FROZEN;
        else if (tick || sel_chg) load = 1'b1;
      end
      FROZEN: begin
        if (press) begin
          state_d = LIVE;
          load    = 1'b1;
        end
      end
      default: state_d = LIVE;
    endcase
  end

  always_comb begin
    case (sel)
      2'd0:    src = pc;
      2'd1:    src = instr;
      2'd2:    src = alu_res;
      default: src = reg_data;
    endcase
`ifdef SSD_SIGNED_MAG_EN
    mag   = src[31] ? (~src + 32'd1) : src;
    neg_d = load ? src[31] : neg_q;
`else
    mag   = src;
`endif
    sat   = (mag > {19'd0, MAX_VAL});
    num_d = load ? (sat ? MAX_VAL : mag[12:0]) : num_q;
    ovf_d = load ? sat : ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LIVE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      tick_cnt_q <= '0;
      sel_q      <= 2'd0;
      num_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef SSD_SIGNED_MAG_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s1_q       <= btn_raw;
      s2_q       <= s1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      sel_q      <= sel;
      num_q      <= num_d;
      ovf_q      <= ovf_d;
`ifdef SSD_SIGNED_MAG_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign num    = num_q;
  assign ovf    = ovf_q;
  assign frozen = (state_q == FROZEN);
`ifdef SSD_SIGNED_MAG_EN
  assign neg    = neg_q;
`endif

endmodule

// File: tb/tb_ssd_value_latch.sv
// Bench for ssd_value_latch: a cycle-level reference model queues expected outputs, a monitor pops and compares.
// Directed scenarios come first, followed by randomized buttons, selects and source values.
module tb_ssd_value_latch;

  localparam int DB  = 4;
  localparam int UPD = 8;
  localparam int MAXV = 8191;

  typedef struct packed {
    logic [12:0] num;
    logic        ovf;
    logic        frozen;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [31:0] pc = 32'd100, instr = '0, alu_res = '0, reg_data = '0;
  logic        btn_raw = 1'b0;
  logic [12:0] num;
  logic        ovf, frozen;
`ifdef SSD_SIGNED_MAG_EN
  logic        neg;
`endif

  int checks = 0;
  int failures = 0;

  exp_t expQ[$];
  bit   mHist[$];
  int   mRun, mSince;
  bit   mLevel, mFrozen;
  logic [1:0] mPrevSel;
  exp_t mOut;

  ssd_value_latch #(
    .DB_CYCLES    (20'd4),
    .UPDATE_CYCLES(24'd8),
    .MAX_VAL      (13'd8191)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .pc      (pc),
    .instr   (instr),
    .alu_res (alu_res),
    .reg_data(reg_data),
    .btn_raw (btn_raw),
`ifdef SSD_SIGNED_MAG_EN
    .neg     (neg),
`endif
    .num     (num),
    .ovf     (ovf),
    .frozen  (frozen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t loadValue(input exp_t e, input logic [31:0] v);
    exp_t   r = e;
    longint m;
`ifdef SSD_SIGNED_MAG_EN
    m = longint'($signed(v));
    if (m < 0) m = -m;
    r.neg = v[31];
`else
    m = longint'({32'd0, v});
`endif
    r.ovf = (m > MAXV);
    r.num = (m > MAXV) ? 13'(MAXV) : 13'(m);
    return r;
  endfunction

  function automatic logic [31:0] pickSource(input logic [1:0] s);
    case (s)
      2'd0:    return pc;
      2'd1:    return instr;
      2'd2:    return alu_res;
      default: return reg_data;
    endcase
  endfunction

  // Reference model: one step per rising edge, using the input values that were stable before the edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mHist = '{};
      mHist.push_back(1'b0);
      mHist.push_back(1'b0);
      mRun = 0; mSince = 0; mLevel = 0; mFrozen = 0; mPrevSel = 2'd0;
      mOut = '0;
      expQ.delete();
    end else begin
      bit s2, press, tick, chg;
      s2 = mHist.pop_front();
      mHist.push_back(btn_raw);
      press = 0;
      if (s2 != mLevel) mRun++; else mRun = 0;
      if (mRun == DB) begin
        mLevel = s2;
        mRun = 0;
        press = s2;
      end
      tick = ((mSince % UPD) == UPD - 1);
      chg  = (sel != mPrevSel);
      if (!mFrozen) begin
        if (press) mFrozen = 1;
        else if (tick || chg) mOut = loadValue(mOut, pickSource(sel));
        mSince = chg ? 0 : mSince + 1;
      end else begin
        mSince++;
        if (press) begin
          mFrozen = 0;
          mOut = loadValue(mOut, pickSource(sel));
        end
      end
      mPrevSel = sel;
      mOut.frozen = mFrozen;
      expQ.push_back(mOut);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mon_rst_num", 32'(num), 32'd0);
      checkOutput("mon_rst_frozen", 32'(frozen), 32'd0);
    end else if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("mon_num", 32'(num), 32'(e.num));
      checkOutput("mon_ovf", 32'(ovf), 32'(e.ovf));
      checkOutput("mon_frozen", 32'(frozen), 32'(e.frozen));
`ifdef SSD_SIGNED_MAG_EN
      checkOutput("mon_neg", 32'(neg), 32'(e.neg));
`endif
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] randVal();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 9000));
    return $urandom;
  endfunction

  task automatic applyStimulus();
    int hold = 1;
    for (int i = 0; i < 400; i++) begin
      hold--;
      if (hold <= 0) begin
        btn_raw = ~btn_raw;
        hold = $urandom_range(1, 9);
      end
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      pc = randVal(); instr = randVal(); alu_res = randVal(); reg_data = randVal();
      waitCycles(1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #1 rst = 1'b0;
    waitCycles(3); #1;
    checkOutput("reset_num", 32'(num), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_frozen", 32'(frozen), 32'd0);
    rst = 1'b1;

    waitCycles(7); #1;
    checkOutput("pre_tick_num", 32'(num), 32'd0);
    waitCycles(1); #1;
    checkOutput("first_tick_num", 32'(num), 32'd100);
    checkOutput("first_tick_ovf", 32'(ovf), 32'd0);

    sel = 2'd2; alu_res = 32'h0000_2710;
    waitCycles(1); #1;
    checkOutput("selchg_num", 32'(num), 32'd8191);
    checkOutput("selchg_ovf", 32'(ovf), 32'd1);
    alu_res = 32'd50;
    waitCycles(7); #1;
    checkOutput("no_early_tick", 32'(num), 32'd8191);
    waitCycles(1); #1;
    checkOutput("tick_after_selchg", 32'(num), 32'd50);

    btn_raw = 1'b1;
    waitCycles(3);
    btn_raw = 1'b0;
    waitCycles(5); #1;
    checkOutput("glitch_frozen", 32'(frozen), 32'd0);

    btn_raw = 1'b1;
    waitCycles(5); #1;
    checkOutput("press_not_yet", 32'(frozen), 32'd0);
    waitCycles(1); #1;
    checkOutput("press_frozen", 32'(frozen), 32'd1);
    sel = 2'd0; pc = 32'd5;
    waitCycles(10); #1;
    checkOutput("frozen_hold_num", 32'(num), 32'd50);

    btn_raw = 1'b0;
    waitCycles(8); #1;
    checkOutput("release_no_effect", 32'(frozen), 32'd1);
    btn_raw = 1'b1;
    waitCycles(5); #1;
    checkOutput("unfreeze_pending", 32'(num), 32'd50);
    waitCycles(1); #1;
    checkOutput("unfreeze_frozen", 32'(frozen), 32'd0);
    checkOutput("unfreeze_num", 32'(num), 32'd5);

    pc = 32'd100;
    waitCycles(8); #1;
    checkOutput("live_reload_num", 32'(num), 32'd100);
    btn_raw = 1'b0;
    waitCycles(8);
    btn_raw = 1'b1;
    waitCycles(6); #1;
    checkOutput("refreeze", 32'(frozen), 32'd1);
    #4 rst = 1'b0;
    #1;
    checkOutput("async_rst_num", 32'(num), 32'd0);
    checkOutput("async_rst_frozen", 32'(frozen), 32'd0);
    checkOutput("async_rst_ovf", 32'(ovf), 32'd0);
    waitCycles(2); #1;
    rst = 1'b1;
    waitCycles(5); #1;
    checkOutput("held_btn_not_yet", 32'(frozen), 32'd0);
    waitCycles(1); #1;
    checkOutput("held_btn_press", 32'(frozen), 32'd1);

    sel = 2'd1; instr = 32'hFFFF_FF9C;
    btn_raw = 1'b0;
    waitCycles(8);
    btn_raw = 1'b1;
    waitCycles(6); #1;
    checkOutput("neg_live", 32'(frozen), 32'd0);
`ifdef SSD_SIGNED_MAG_EN
    checkOutput("neg_num", 32'(num), 32'd100);
    checkOutput("neg_flag", 32'(neg), 32'd1);
    checkOutput("neg_ovf", 32'(ovf), 32'd0);
`else
    checkOutput("unsigned_big_num", 32'(num), 32'd8191);
    checkOutput("unsigned_big_ovf", 32'(ovf), 32'd1);
`endif
    reg_data = 32'd7; sel = 2'd3;
    waitCycles(1); #1;
    checkOutput("reg_sel_num", 32'(num), 32'd7);
    instr = 32'h8000_0000; sel = 2'd1;
    waitCycles(1); #1;
    checkOutput("min_int_num", 32'(num), 32'd8191);
    checkOutput("min_int_ovf", 32'(ovf), 32'd1);
`ifdef SSD_SIGNED_MAG_EN
    checkOutput("min_int_neg", 32'(neg), 32'd1);
`endif

    applyStimulus();
    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
